// File: rtl/convex_pkg.sv
// Shared types for the hull point feeder: FSM states, coordinate/slice widths and the point record.
package convex_pkg;
    localparam int COORD_W = 10;
    localparam int SLICE_W = 5;

    typedef enum logic [2:0] {IDLE, XH, XL, YH, YL} feed_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    function automatic logic [SLICE_W-1:0] hi_slice(input logic [COORD_W-1:0] c);
        return c[COORD_W-1:SLICE_W];
    endfunction

    function automatic logic [SLICE_W-1:0] lo_slice(input logic [COORD_W-1:0] c);
        return c[SLICE_W-1:0];
    endfunction
endpackage

// File: rtl/pt_fifo.sv
// Synchronous point FIFO; head is registered storage, so a word is poppable one edge after its push.
// Latency 1 edge push-to-pop; push is refused while full even if a pop happens on the same edge.
module pt_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 20
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // Extra MSB on each pointer tells a full wrap apart from empty.
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o    = (wr_q == rd_q);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

// File: rtl/pt_feeder.sv
// Buffers host points and serialises each as four 5-bit slices (XH,XL,YH,YL) to the hull engine; logs drops.
// Latency 1 cycle from the READ_PT sampling edge to the first slice; IN_RDY low while the FIFO is full.
module pt_feeder
    import convex_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_V,
    input  logic [9:0]         IN_X,
    input  logic [9:0]         IN_Y,
    output logic               IN_RDY,
    input  logic               READ_PT,
    output logic [4:0]         PT_XY,
    output logic               PT_ACT,
    input  logic               DROP_V,
    input  logic [9:0]         DROP_X,
    input  logic [9:0]         DROP_Y,
    output logic [9:0]         LAST_DROP_X,
    output logic [9:0]         LAST_DROP_Y,
    output logic [CW-1:0]      SENT_CNT,
    output logic [CW-1:0]      DROP_CNT,
    output logic               EMPTY_REQ
);
    feed_state_t          state_q;
    point_t               sr_q;
    logic [SLICE_W-1:0]   pt_xy_q;
    logic                 pt_act_q;
    logic [CW-1:0]        sent_q;
    logic                 empty_req_q;

    logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
    logic [COORD_W-1:0]   last_x_q, last_x_d, last_y_q, last_y_d;

    logic                 fifo_full, fifo_empty, start_ok, at_boundary;
    logic [$bits(point_t)-1:0] fifo_head;
    point_t               head;

    assign head        = point_t'(fifo_head);
    assign at_boundary = (state_q == IDLE) || (state_q == YL);
    assign start_ok    = at_boundary && READ_PT && !fifo_empty;

    pt_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(point_t))
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push_i     (IN_V),
        .push_dat_i ({IN_X, IN_Y}),
        .pop_i      (start_ok),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Slice and PT_ACT are registered alongside the state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            pt_xy_q     <= '0;
            pt_act_q    <= 1'b0;
            sent_q      <= '0;
            empty_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, YL: begin
                    if (state_q == YL) sent_q <= sent_q + CW'(1);
                    if (start_ok) begin
                        state_q  <= XH;
                        sr_q     <= head;
                        pt_xy_q  <= hi_slice(head.x);
                        pt_act_q <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        pt_xy_q  <= '0;
                        pt_act_q <= 1'b0;
                        if (READ_PT) empty_req_q <= 1'b1;
                    end
                end
                XH: begin
                    state_q <= XL;
                    pt_xy_q <= lo_slice(sr_q.x);
                end
                XL: begin
                    state_q <= YH;
                    pt_xy_q <= hi_slice(sr_q.y);
                end
                YH: begin
                    state_q <= YL;
                    pt_xy_q <= lo_slice(sr_q.y);
                end
                default: begin
                    state_q  <= IDLE;
                    pt_xy_q  <= '0;
                    pt_act_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        if (DROP_V) begin
            drop_cnt_d = drop_cnt_q + CW'(1);
            last_x_d   = DROP_X;
            last_y_d   = DROP_Y;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt_q <= '0;
            last_x_q   <= '0;
            last_y_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
        end
    end

    assign IN_RDY      = !fifo_full;
    assign PT_XY       = pt_xy_q;
    assign PT_ACT      = pt_act_q;
    assign SENT_CNT    = sent_q;
    assign EMPTY_REQ   = empty_req_q;
    assign DROP_CNT    = drop_cnt_q;
    assign LAST_DROP_X = last_x_q;
    assign LAST_DROP_Y = last_y_q;
endmodule

// File: tb/tb_pt_feeder.sv
// Bench for pt_feeder: transaction-level point model feeds a slice scoreboard checked by a negedge monitor.
module tb_pt_feeder;
    localparam int DEPTH = 16;
    localparam int CW    = 8;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pnt_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_V = 1'b0;
    logic [9:0]    IN_X = '0, IN_Y = '0;
    logic          IN_RDY;
    logic          READ_PT = 1'b0;
    logic [4:0]    PT_XY;
    logic          PT_ACT;
    logic          DROP_V = 1'b0;
    logic [9:0]    DROP_X = '0, DROP_Y = '0;
    logic [9:0]    LAST_DROP_X, LAST_DROP_Y;
    logic [CW-1:0] SENT_CNT, DROP_CNT;
    logic          EMPTY_REQ;

    pt_feeder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .IN_V(IN_V), .IN_X(IN_X), .IN_Y(IN_Y), .IN_RDY(IN_RDY),
        .READ_PT(READ_PT), .PT_XY(PT_XY), .PT_ACT(PT_ACT),
        .DROP_V(DROP_V), .DROP_X(DROP_X), .DROP_Y(DROP_Y),
        .LAST_DROP_X(LAST_DROP_X), .LAST_DROP_Y(LAST_DROP_Y),
        .SENT_CNT(SENT_CNT), .DROP_CNT(DROP_CNT), .EMPTY_REQ(EMPTY_REQ)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stored points, pending slices, and how far into a point's 4-slot transmission we are.
    pnt_t          mq[$];
    logic [4:0]    exp_q[$];
    int            slot = 0;
    logic [CW-1:0] m_sent = '0, m_drops = '0;
    logic [9:0]    m_ldx = '0, m_ldy = '0;
    logic          m_ereq = 1'b0;
    int            m_size;
    pnt_t          m_p;

    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            exp_q.delete();
            slot = 0; m_sent = '0; m_drops = '0; m_ldx = '0; m_ldy = '0; m_ereq = 1'b0;
        end else begin
            m_size = mq.size();
            if (slot == 4) m_sent = m_sent + 1'b1;
            if (slot == 0 || slot == 4) begin
                if (READ_PT && m_size > 0) begin
                    m_p = mq.pop_front();
                    exp_q.push_back(5'(m_p.x / 32));
                    exp_q.push_back(5'(m_p.x % 32));
                    exp_q.push_back(5'(m_p.y / 32));
                    exp_q.push_back(5'(m_p.y % 32));
                    slot = 1;
                end else begin
                    slot = 0;
                    if (READ_PT) m_ereq = 1'b1;
                end
            end else begin
                slot = slot + 1;
            end
            if (IN_V && m_size < DEPTH) mq.push_back({IN_X, IN_Y});
            if (DROP_V) begin
                m_drops = m_drops + 1'b1;
                m_ldx = DROP_X;
                m_ldy = DROP_Y;
            end
        end
    end

    bit mon_en = 1'b0;
    logic [4:0] exp_slice;

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("pt_act", PT_ACT, (slot != 0));
            if (PT_ACT === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("slice_unexpected", 1, exp_q.size());
                end else begin
                    exp_slice = exp_q.pop_front();
                    chk("pt_xy", PT_XY, exp_slice);
                end
            end else begin
                chk("pt_xy_idle", PT_XY, 0);
            end
            chk("in_rdy", IN_RDY, (mq.size() < DEPTH));
            chk("sent_cnt", SENT_CNT, m_sent);
            chk("drop_cnt", DROP_CNT, m_drops);
            chk("last_drop_x", LAST_DROP_X, m_ldx);
            chk("last_drop_y", LAST_DROP_Y, m_ldy);
            chk("empty_req", EMPTY_REQ, m_ereq);
        end
    end

    task automatic wait_act(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (PT_ACT === 1'b1) break;
            @(negedge CLK);
        end
        chk("act_wait", PT_ACT, 1);
    endtask

    task automatic expect_slices(input logic [4:0] a, b, c, d);
        logic [4:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        wait_act(20);
        for (int i = 0; i < 4; i++) begin
            chk("dir_act", PT_ACT, 1);
            chk("dir_slice", PT_XY, v[i]);
            @(negedge CLK);
        end
        chk("dir_act_end", PT_ACT, 0);
    endtask

    task automatic push_one(input logic [9:0] x, input logic [9:0] y);
        IN_V = 1'b1; IN_X = x; IN_Y = y;
        @(negedge CLK);
        IN_V = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_act", PT_ACT, 0);
        chk("rst_xy", PT_XY, 0);
        chk("rst_rdy", IN_RDY, 1);
        chk("rst_sent", SENT_CNT, 0);
        chk("rst_ereq", EMPTY_REQ, 0);
    endtask

    int cnt, first, last, base;
    bit done;

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        mon_en = 1'b1;
        chk("rst_rdy0", IN_RDY, 1);
        chk("rst_act0", PT_ACT, 0);

        // Single point (300,517)
        push_one(10'd300, 10'd517);
        READ_PT = 1'b1;
        expect_slices(5'd9, 5'd12, 5'd16, 5'd5);
        READ_PT = 1'b0;
        @(negedge CLK);
        chk("sent_one", SENT_CNT, 1);

        // Three points streamed back-to-back with READ_PT held
        base = SENT_CNT; cnt = 0; first = -1; last = -1;
        READ_PT = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i < 3) begin
                IN_V = 1'b1; IN_X = 10'($urandom_range(0, 1023)); IN_Y = 10'($urandom_range(0, 1023));
            end else begin
                IN_V = 1'b0;
            end
            @(negedge CLK);
            if (PT_ACT) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        READ_PT = 1'b0;
        chk("burst_act_cycles", cnt, 12);
        chk("burst_contig", last - first + 1, 12);
        chk("burst_sent", SENT_CNT - 8'(base), 3);
        chk("burst_idle", PT_ACT, 0);

        // Request while empty, then a late push
        do_reset();
        READ_PT = 1'b1;
        repeat (5) @(negedge CLK);
        chk("empty_req_set", EMPTY_REQ, 1);
        push_one(10'd1, 10'd1023);
        chk("late_push_no_act", PT_ACT, 0);
        expect_slices(5'd0, 5'd1, 5'd31, 5'd31);
        READ_PT = 1'b0;
        @(negedge CLK);

        // Overfill: DEPTH+2 pushes with no reads
        for (int i = 0; i < DEPTH + 2; i++) begin
            IN_V = 1'b1; IN_X = 10'($urandom_range(0, 1023)); IN_Y = 10'($urandom_range(0, 1023));
            @(negedge CLK);
            if (i == DEPTH - 2) chk("ovf_rdy_before", IN_RDY, 1);
            if (i == DEPTH - 1) chk("ovf_rdy_full", IN_RDY, 0);
        end
        IN_V = 1'b0;
        READ_PT = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4 * DEPTH + 10; i++) begin
            @(negedge CLK);
            if (PT_ACT) cnt++;
        end
        READ_PT = 1'b0;
        chk("ovf_readout_cycles", cnt, 4 * DEPTH);

        // 257 drops, last (7,900)
        do_reset();
        for (int i = 0; i < 257; i++) begin
            DROP_V = 1'b1;
            DROP_X = (i == 256) ? 10'd7   : 10'($urandom_range(0, 1023));
            DROP_Y = (i == 256) ? 10'd900 : 10'($urandom_range(0, 1023));
            @(negedge CLK);
        end
        DROP_V = 1'b0;
        chk("drop_cnt_wrap", DROP_CNT, 1);
        chk("drop_last_x", LAST_DROP_X, 7);
        chk("drop_last_y", LAST_DROP_Y, 900);

        // Reset during XL aborts the transfer
        push_one(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
        READ_PT = 1'b1;
        wait_act(20);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        READ_PT = 1'b0;
        chk("abort_act", PT_ACT, 0);
        chk("abort_xy", PT_XY, 0);
        chk("abort_rdy", IN_RDY, 1);
        repeat (3) @(negedge CLK);
        chk("abort_quiet", PT_ACT, 0);
        push_one(10'd300, 10'd517);
        READ_PT = 1'b1;
        expect_slices(5'd9, 5'd12, 5'd16, 5'd5);
        READ_PT = 1'b0;
        @(negedge CLK);
        chk("abort_sent", SENT_CNT, 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            IN_V    = ($urandom_range(0, 1) == 1);
            IN_X    = 10'($urandom_range(0, 1023));
            IN_Y    = 10'($urandom_range(0, 1023));
            READ_PT = ($urandom_range(0, 3) != 0);
            DROP_V  = ($urandom_range(0, 4) == 0);
            DROP_X  = 10'($urandom_range(0, 1023));
            DROP_Y  = 10'($urandom_range(0, 1023));
            @(negedge CLK);
        end
        IN_V = 1'b0; DROP_V = 1'b0; READ_PT = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 4 * DEPTH + 40; i++) begin
            @(negedge CLK);
            if (mq.size() == 0 && slot == 0) begin
                done = 1'b1;
                break;
            end
        end
        READ_PT = 1'b0;
        chk("drain_done", done, 1);
        repeat (2) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pt_feeder.md
PT_FEEDER -- requirements
Module: pt_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, point FIFO depth in entries (power of two, 2..64).
REQ-002 SHALL have parameter CW, default 8, width of the SENT_CNT and DROP_CNT counters.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port IN_V  input  1  host point valid.
REQ-006 SHALL have port IN_X  input  10  host point X coordinate.
REQ-007 SHALL have port IN_Y  input  10  host point Y coordinate.
REQ-008 SHALL have port IN_RDY  output  1  FIFO not full; a push occurs when IN_V & IN_RDY at a clock edge.
REQ-009 SHALL have port READ_PT  input  1  point request from the hull engine, level-sampled.
REQ-010 SHALL have port PT_XY  output  5  serialized coordinate slice.
REQ-011 SHALL have port PT_ACT  output  1  high while PT_XY carries a valid slice.
REQ-012 SHALL have port DROP_V  input  1  dropped-point strobe from the hull engine.
REQ-013 SHALL have port DROP_X  input  10  dropped-point X.
REQ-014 SHALL have port DROP_Y  input  10  dropped-point Y.
REQ-015 SHALL have port LAST_DROP_X  output  10  X of the most recent drop.
REQ-016 SHALL have port LAST_DROP_Y  output  10  Y of the most recent drop.
REQ-017 SHALL have port SENT_CNT  output  CW  number of points fully transmitted, modulo 2^CW.
REQ-018 SHALL have port DROP_CNT  output  CW  number of DROP_V cycles, modulo 2^CW.
REQ-019 SHALL have port EMPTY_REQ  output  1  sticky flag: READ_PT was sampled while a transfer could start but the FIFO was empty.

Function
REQ-020 SHALL implement FSM states IDLE, XH, XL, YH, YL; PT_XY = X[9:5], X[4:0], Y[9:5], Y[4:0] in XH, XL, YH, YL respectively, and 0 in IDLE.
REQ-021 SHALL assert PT_ACT exactly in XH, XL, YH and YL.
REQ-022 SHALL transition IDLE->XH on an edge with READ_PT=1 and FIFO non-empty, popping the head into the shift register at that same edge.
REQ-023 SHALL advance XH->XL->YH->YL unconditionally, one state per cycle, regardless of READ_PT.
REQ-024 SHALL, in YL, sample READ_PT: READ_PT=1 with FIFO non-empty -> XH with a pop (back-to-back, no idle cycle); otherwise -> IDLE.
REQ-025 SHALL provide a latency of exactly 1 cycle from the READ_PT sampling edge to the first slice on PT_XY.
REQ-026 SHALL increment SENT_CNT on the edge that leaves YL.
REQ-027 SHALL, when READ_PT=1 is sampled in IDLE or YL with the FIFO empty, stay in or go to IDLE, set EMPTY_REQ, and start the transfer on a later edge once data is present and READ_PT is still 1.
REQ-028 SHALL implement the FIFO with no fall-through: a word pushed at edge N is poppable at edge N+1 at the earliest.
REQ-029 SHALL complete both a push and a pop on the same edge when the FIFO is non-empty and not full; occupancy is then unchanged.
REQ-030 SHALL drive IN_RDY=0 when the FIFO is full, and ignore IN_V while IN_RDY=0.
REQ-031 SHALL, on each edge with DROP_V=1, capture DROP_X/DROP_Y into LAST_DROP_X/Y and increment DROP_CNT, independently of FSM state.
REQ-032 SHALL wrap both counters from 2^CW-1 to 0.
REQ-033 SHALL wrap the FIFO read/write pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.

Reset
REQ-034 SHALL, on RST=1 at an edge, enter IDLE, empty the FIFO, and clear SENT_CNT, DROP_CNT, LAST_DROP_X/Y and EMPTY_REQ, with PT_XY=0, PT_ACT=0 and IN_RDY=1 from the next cycle.
REQ-035 SHALL abort any in-progress transfer on a mid-transfer RST with no further slices, and SHALL take precedence over simultaneous push, pop or DROP_V.

Structure
REQ-036 SHALL place the state enum, coordinate width (10), slice width (5) and point struct {X, Y} in a shared package, convex_pkg.
REQ-037 SHALL contain one sub-module, pt_fifo, a parameterized synchronous FIFO; the FSM, serializer and drop logger SHALL reside in pt_feeder.

Verification
REQ-038 SHALL verify: push (300,517), then hold READ_PT=1 -> PT_XY=9,12,16,5 on 4 consecutive cycles, PT_ACT high for exactly those cycles, SENT_CNT=1.
REQ-039 SHALL verify: push 3 points with READ_PT held high -> 12 contiguous PT_ACT cycles with no gap, SENT_CNT=3, FIFO empty, then IDLE.
REQ-040 SHALL verify: READ_PT=1 with FIFO empty for 5 cycles, then push (1,1023) -> EMPTY_REQ=1, and 2 cycles after the push edge PT_XY=0,1,31,31.
REQ-041 SHALL verify: push DEPTH+2 points with READ_PT=0 -> IN_RDY falls after DEPTH accepted, the 2 extra points are lost, and a later readout returns exactly the first DEPTH points in order.
REQ-042 SHALL verify: DROP_V pulsed 257 times with CW=8, last drop (7,900) -> DROP_CNT=1, LAST_DROP=(7,900).
REQ-043 SHALL verify: RST asserted during XL -> PT_XY=0 and PT_ACT=0 next cycle, IN_RDY=1, and a fresh push/read sequence then behaves as in REQ-038.
